// File: rtl/bg_fetch_scheduler_if.sv
// ---------------------------------------------------------------------------
// bg_fetch_scheduler_if
// VRAM read port between the background fetch scheduler and the VRAM arbiter.
//   vram_req   : read request, held until the cycle in which vram_ack is high
//   vram_addr  : byte address of the read; held stable while vram_req is high
//   vram_ack   : grant, vram_rdata is valid in the same cycle
//   vram_rdata : halfword at vram_addr with bit 0 cleared
// master = scheduler side, slave = arbiter / memory side.
// ---------------------------------------------------------------------------
interface bg_fetch_scheduler_if;
    logic        vram_req;
    logic [16:0] vram_addr;
    logic        vram_ack;
    logic [15:0] vram_rdata;

    modport master (
        output vram_req,
        output vram_addr,
        input  vram_ack,
        input  vram_rdata
    );

    modport slave (
        input  vram_req,
        input  vram_addr,
        output vram_ack,
        output vram_rdata
    );
endinterface

// File: rtl/bg_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// bg_fetch_scheduler
// Walks the enabled backgrounds of one pixel in ascending BG order. For each
// enabled BG it reads the screen entry, then the character byte holding the
// pixel, and presents the result to the BG data formatter for one cycle.
//
// Ports
//   clock, rst_n      : single clock, asynchronous active-low reset
//   pixel_go          : one-cycle start pulse (ignored while a pass is active)
//   bg_enable         : per-BG enable, latched on an accepted pixel_go
//   bg_palmode        : per-BG 256-color (1) / 16-color (0), latched likewise
//   px_row, px_col    : pixel position inside the tile, latched likewise
//   map_addr          : screen entry byte address of BG cur_bg (external mux)
//   char_base         : character base byte address of BG cur_bg (same mux)
//   cur_bg            : BG currently being fetched; selects the external mux
//   vram              : VRAM read port (master side)
//   out_valid, out_*  : formatter inputs, qualified by the out_valid strobe
//   busy              : a pass is active
//   done              : one-cycle end-of-pass pulse
//   overrun           : sticky, a pixel_go arrived while busy
// ---------------------------------------------------------------------------
module bg_fetch_scheduler (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 pixel_go,
    input  logic [3:0]           bg_enable,
    input  logic [3:0]           bg_palmode,
    input  logic [2:0]           px_row,
    input  logic [2:0]           px_col,
    input  logic [16:0]          map_addr,
    input  logic [16:0]          char_base,
    output logic [1:0]           cur_bg,
    bg_fetch_scheduler_if.master vram,
    output logic                 out_valid,
    output logic [1:0]           out_bgno,
    output logic [3:0]           out_paletteno,
    output logic [14:0]          out_data,
    output logic                 out_dot_sel,
    output logic                 out_palettemode,
    output logic                 out_bgused,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        IDLE,
        MAP_REQ,
        CHAR_REQ,
        EMIT,
        NEXT
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Fields latched at the start of a pass
    logic [3:0]  en_q;
    logic [3:0]  mode_q;
    logic [2:0]  row_q;
    logic [2:0]  col_q;

    // Fields latched from the screen entry
    logic [9:0]  tile;
    logic        hflip;
    logic        vflip;
    logic [3:0]  pal;

    logic [2:0]  first_sel;
    logic [2:0]  nxt_sel;
    logic [2:0]  r_eff;
    logic [2:0]  c_eff;
    logic        mode_cur;
    logic [16:0] char_addr;
    logic [7:0]  rd_byte;

    // Lowest enabled BG index >= from; result is {found, index}.
    function automatic logic [2:0] find_bg(input logic [3:0] en, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (en[i] && (3'(i) >= from)) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

    assign first_sel = find_bg(bg_enable, 3'd0);
    assign nxt_sel   = find_bg(en_q, 3'(cur_bg) + 3'd1);

    assign mode_cur  = mode_q[cur_bg];
    assign r_eff     = vflip ? (3'd7 - row_q) : row_q;
    assign c_eff     = hflip ? (3'd7 - col_q) : col_q;

    // 16-color tiles are 32 bytes with two pixels per byte, so the column
    // contributes c/2 and c[0] later picks the nibble; 256-color tiles are
    // 64 bytes with one pixel per byte. The sum wraps at 17 bits.
    assign char_addr = mode_cur
        ? (char_base + 17'({tile, 6'b0}) + 17'({r_eff, 3'b0}) + 17'(c_eff))
        : (char_base + 17'({tile, 5'b0}) + 17'({r_eff, 2'b0}) + 17'(c_eff[2:1]));

    // The returned halfword is aligned; the odd byte sits in the upper half.
    assign rd_byte = char_addr[0] ? vram.vram_rdata[15:8] : vram.vram_rdata[7:0];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request and address are decoded from the state, so they stay asserted
    // and stable until the ack moves the state on, and fall the cycle after.
    always_comb begin
        state_nxt      = state;
        vram.vram_req  = 1'b0;
        vram.vram_addr = 17'd0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                if (pixel_go && first_sel[2]) begin
                    state_nxt = MAP_REQ;
                end
            end
            MAP_REQ: begin
                vram.vram_req  = 1'b1;
                vram.vram_addr = map_addr & 17'h1FFFE;
                if (vram.vram_ack) begin
                    state_nxt = CHAR_REQ;
                end
            end
            CHAR_REQ: begin
                vram.vram_req  = 1'b1;
                vram.vram_addr = char_addr;
                if (vram.vram_ack) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                state_nxt = NEXT;
            end
            NEXT: begin
                state_nxt = nxt_sel[2] ? MAP_REQ : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            en_q            <= '0;
            mode_q          <= '0;
            row_q           <= '0;
            col_q           <= '0;
            cur_bg          <= '0;
            tile            <= '0;
            hflip           <= 1'b0;
            vflip           <= 1'b0;
            pal             <= '0;
            out_valid       <= 1'b0;
            out_bgno        <= '0;
            out_paletteno   <= '0;
            out_data        <= '0;
            out_dot_sel     <= 1'b0;
            out_palettemode <= 1'b0;
            out_bgused      <= 1'b0;
            done            <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;

            // NEXT counts as busy, so a start in the done cycle is an overrun.
            if (pixel_go && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pixel_go) begin
                        en_q   <= bg_enable;
                        mode_q <= bg_palmode;
                        row_q  <= px_row;
                        col_q  <= px_col;
                        cur_bg <= first_sel[1:0];
                        done   <= ~first_sel[2];
                    end
                end
                MAP_REQ: begin
                    if (vram.vram_ack) begin
                        tile  <= vram.vram_rdata[9:0];
                        hflip <= vram.vram_rdata[10];
                        vflip <= vram.vram_rdata[11];
                        pal   <= vram.vram_rdata[15:12];
                    end
                end
                CHAR_REQ: begin
                    // Loading here makes the strobe and data visible in EMIT.
                    if (vram.vram_ack) begin
                        out_valid       <= 1'b1;
                        out_bgno        <= cur_bg;
                        out_paletteno   <= pal;
                        out_data        <= {7'd0, rd_byte};
                        out_dot_sel     <= mode_cur ? 1'b0 : c_eff[0];
                        out_palettemode <= mode_cur;
                        out_bgused      <= 1'b1;
                    end
                end
                EMIT: begin
                    // Registered so done is high during the final NEXT cycle.
                    done <= ~nxt_sel[2];
                end
                NEXT: begin
                    if (nxt_sel[2]) begin
                        cur_bg <= nxt_sel[1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bg_fetch_scheduler.sv
module tb_bg_fetch_scheduler;

    typedef struct packed {
        logic [1:0]  bg;
        logic [16:0] addr;
    } acc_t;

    typedef struct packed {
        logic [1:0]  bg;
        logic [3:0]  pal;
        logic [14:0] data;
        logic        dot;
        logic        mode;
    } emit_t;

    logic        clock = 1'b0;
    logic        rst_n = 1'b1;
    logic        pixel_go = 1'b0;
    logic [3:0]  bg_enable = 4'd0;
    logic [3:0]  bg_palmode = 4'd0;
    logic [2:0]  px_row = 3'd0;
    logic [2:0]  px_col = 3'd0;
    logic [16:0] map_addr;
    logic [16:0] char_base;
    logic [1:0]  cur_bg;
    logic        out_valid;
    logic [1:0]  out_bgno;
    logic [3:0]  out_paletteno;
    logic [14:0] out_data;
    logic        out_dot_sel;
    logic        out_palettemode;
    logic        out_bgused;
    logic        busy;
    logic        done;
    logic        overrun;

    logic [16:0] map_cfg [4];
    logic [16:0] char_cfg [4];
    logic [15:0] mem [int];

    int checks = 0;
    int passes = 0;
    int fails = 0;
    int cyc = 0;
    int go_cyc = 0;
    int first_valid_cyc = -1;
    int req_cycles = 0;

    int max_wait = 0;
    int fixed_wait = -1;
    int ack_limit = 32'h3FFF_FFFF;
    int ack_total = 0;
    bit inject_ack = 1'b0;

    acc_t  acc_q[$];
    acc_t  exp_acc_q[$];
    emit_t obs_q[$];
    emit_t exp_emit_q[$];

    bg_fetch_scheduler_if vif ();

    bg_fetch_scheduler dut (
        .clock           (clock),
        .rst_n           (rst_n),
        .pixel_go        (pixel_go),
        .bg_enable       (bg_enable),
        .bg_palmode      (bg_palmode),
        .px_row          (px_row),
        .px_col          (px_col),
        .map_addr        (map_addr),
        .char_base       (char_base),
        .cur_bg          (cur_bg),
        .vram            (vif),
        .out_valid       (out_valid),
        .out_bgno        (out_bgno),
        .out_paletteno   (out_paletteno),
        .out_data        (out_data),
        .out_dot_sel     (out_dot_sel),
        .out_palettemode (out_palettemode),
        .out_bgused      (out_bgused),
        .busy            (busy),
        .done            (done),
        .overrun         (overrun)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // External per-BG configuration mux
    assign map_addr  = map_cfg[cur_bg];
    assign char_base = char_cfg[cur_bg];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // VRAM content: explicit entries, otherwise a fixed hash of the address
    function automatic logic [15:0] rd(input logic [16:0] a);
        int          key;
        logic [31:0] h;
        key = int'({a[16:1], 1'b0});
        if (mem.exists(key)) return mem[key];
        h = 32'(key) * 32'h9E37_79B1;
        return h[31:16] ^ h[15:0];
    endfunction

    // Reference: what one pixel pass must read and emit
    task automatic model(input logic [3:0] en, input logic [3:0] pm,
                         input logic [2:0] row, input logic [2:0] col);
        logic [16:0] ma;
        logic [15:0] ent;
        logic [16:0] ca;
        logic [15:0] w;
        logic [7:0]  by;
        int          r;
        int          c;
        int          ca_i;
        emit_t       e;
        for (int b = 0; b < 4; b++) begin
            if (en[b]) begin
                ma   = {map_cfg[b][16:1], 1'b0};
                ent  = rd(ma);
                r    = ent[11] ? 7 - int'(row) : int'(row);
                c    = ent[10] ? 7 - int'(col) : int'(col);
                if (pm[b]) ca_i = int'(char_cfg[b]) + int'(ent[9:0]) * 64 + r * 8 + c;
                else       ca_i = int'(char_cfg[b]) + int'(ent[9:0]) * 32 + r * 4 + c / 2;
                ca   = 17'(ca_i);
                w    = rd(ca);
                by   = ca[0] ? w[15:8] : w[7:0];
                exp_acc_q.push_back({2'(b), ma});
                exp_acc_q.push_back({2'(b), ca});
                e.bg   = 2'(b);
                e.pal  = ent[15:12];
                e.data = {7'd0, by};
                e.dot  = pm[b] ? 1'b0 : 1'(c % 2);
                e.mode = pm[b];
                exp_emit_q.push_back(e);
            end
        end
    endtask

    // VRAM responder with programmable wait and address stability check
    initial begin : responder
        int          wcnt;
        int          wtgt;
        bit          pend;
        logic [16:0] paddr;
        wcnt = 0; wtgt = 0; pend = 1'b0; paddr = '0;
        vif.vram_ack   = 1'b0;
        vif.vram_rdata = 16'd0;
        forever begin
            @(negedge clock);
            vif.vram_ack = 1'b0;
            if (inject_ack) begin
                vif.vram_ack   = 1'b1;
                vif.vram_rdata = 16'hFFFF;
                pend = 1'b0;
            end else if (rst_n && vif.vram_req === 1'b1) begin
                if (!pend) begin
                    pend  = 1'b1;
                    paddr = vif.vram_addr;
                    wcnt  = 0;
                    wtgt  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_wait, 0));
                end else begin
                    chk("addr_stable", 32'(vif.vram_addr), 32'(paddr));
                end
                if (wcnt >= wtgt && ack_total < ack_limit) begin
                    vif.vram_ack   = 1'b1;
                    vif.vram_rdata = rd(paddr);
                    acc_q.push_back({cur_bg, paddr});
                    ack_total++;
                    pend = 1'b0;
                end else begin
                    wcnt++;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    // Output monitor
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (vif.vram_req === 1'b1) req_cycles++;
            if (out_valid === 1'b1) begin
                obs_q.push_back({out_bgno, out_paletteno, out_data, out_dot_sel, out_palettemode});
                chk("bgused_with_valid", 32'(out_bgused), 32'd1);
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        rst_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic randomize_cfg();
        for (int b = 0; b < 4; b++) begin
            map_cfg[b]  = 17'($urandom);
            char_cfg[b] = 17'($urandom);
        end
    endtask

    task automatic run_pixel(input logic [3:0] en, input logic [3:0] pm,
                             input logic [2:0] row, input logic [2:0] col,
                             input bit go_mid, input bit go_at_done,
                             input string tag, output int done_n);
        bit seen;
        seen   = 1'b0;
        done_n = -1;
        model(en, pm, row, col);
        first_valid_cyc = -1;
        @(negedge clock);
        bg_enable  = en;
        bg_palmode = pm;
        px_row     = row;
        px_col     = col;
        pixel_go   = 1'b1;
        go_cyc     = cyc;
        @(negedge clock);
        pixel_go   = 1'b0;
        bg_enable  = 4'($urandom);
        bg_palmode = 4'($urandom);
        px_row     = 3'($urandom);
        px_col     = 3'($urandom);
        for (int n = 0; n < 500; n++) begin
            if (done === 1'b1) begin
                seen   = 1'b1;
                done_n = n;
                break;
            end
            pixel_go = go_mid && (n == 1);
            @(negedge clock);
        end
        pixel_go = go_at_done && seen;
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        @(negedge clock);
        pixel_go = 1'b0;
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
        @(negedge clock);
        @(negedge clock);
        chk({tag, " idle_after"}, 32'(busy), 32'd0);
    endtask

    task automatic compare_pass(input string tag);
        chk({tag, " emit_count"}, 32'(obs_q.size()), 32'(exp_emit_q.size()));
        chk({tag, " access_count"}, 32'(acc_q.size()), 32'(exp_acc_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_emit_q.size(); i++)
            chk({tag, " emit"}, 32'(obs_q[i]), 32'(exp_emit_q[i]));
        for (int i = 0; i < acc_q.size() && i < exp_acc_q.size(); i++)
            chk({tag, " access"}, 32'(acc_q[i]), 32'(exp_acc_q[i]));
        obs_q.delete();
        exp_emit_q.delete();
        acc_q.delete();
        exp_acc_q.delete();
    endtask

    initial begin : main
        int          dn;
        int          req0;
        logic [3:0]  ren;
        logic [3:0]  rpm;
        logic [2:0]  rrow;
        logic [2:0]  rcol;

        for (int b = 0; b < 4; b++) begin
            map_cfg[b]  = 17'd0;
            char_cfg[b] = 17'd0;
        end

        // Reset state
        #2 rst_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst vram_req", 32'(vif.vram_req), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst overrun", 32'(overrun), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst cur_bg", 32'(cur_bg), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clock);

        // Single BG, 16-color, zero-wait
        max_wait    = 0;
        map_cfg[0]  = 17'h01000;
        char_cfg[0] = 17'h04000;
        mem[32'h1000] = 16'h3005;
        mem[32'h40AA] = 16'h7B7B;
        run_pixel(4'b0001, 4'b0000, 3'd2, 3'd5, 1'b0, 1'b0, "bg0_16c", dn);
        chk("bg0_16c latency", 32'(first_valid_cyc - go_cyc), 32'd3);
        chk("bg0_16c done_cycle", 32'(dn), 32'd3);
        if (acc_q.size() == 2) chk("bg0_16c char_addr", 32'(acc_q[1].addr), 32'h40AA);
        compare_pass("bg0_16c");
        chk("bg0_16c out_data_hold", 32'(out_data), 32'h007B);
        chk("bg0_16c dot_sel", 32'(out_dot_sel), 32'd1);
        chk("bg0_16c palette", 32'(out_paletteno), 32'd3);

        // Both flips, 256-color, char base 0
        map_cfg[0]  = 17'h02000;
        char_cfg[0] = 17'h00000;
        mem[32'h2000] = 16'h0C01;
        mem[32'h007E] = 16'hA55A;
        run_pixel(4'b0001, 4'b0001, 3'd0, 3'd0, 1'b0, 1'b0, "flip256", dn);
        if (acc_q.size() == 2) chk("flip256 char_addr", 32'(acc_q[1].addr), 32'h007F);
        compare_pass("flip256");
        chk("flip256 out_data", 32'(out_data), 32'h00A5);
        chk("flip256 palmode", 32'(out_palettemode), 32'd1);

        // Sparse enables, 256-color, random waits
        randomize_cfg();
        max_wait = 2;
        run_pixel(4'b1010, 4'b1111, 3'd3, 3'd6, 1'b0, 1'b0, "sparse", dn);
        chk("sparse count", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() == 2) begin
            chk("sparse first_bg", 32'(obs_q[0].bg), 32'd1);
            chk("sparse second_bg", 32'(obs_q[1].bg), 32'd3);
        end
        compare_pass("sparse");

        // Held request: five wait cycles on every read
        fixed_wait = 5;
        req0 = req_cycles;
        run_pixel(4'b0100, 4'b0000, 3'd7, 3'd1, 1'b0, 1'b0, "wait5", dn);
        chk("wait5 req_cycles", 32'(req_cycles - req0), 32'd12);
        compare_pass("wait5");
        fixed_wait = -1;

        // pixel_go during a pass
        chk("overrun before", 32'(overrun), 32'd0);
        run_pixel(4'b0111, 4'b0101, 3'd4, 3'd2, 1'b1, 1'b0, "go_mid", dn);
        compare_pass("go_mid");
        chk("go_mid overrun", 32'(overrun), 32'd1);

        // No BG enabled
        req0 = req_cycles;
        run_pixel(4'b0000, 4'b1111, 3'd1, 3'd1, 1'b0, 1'b0, "empty", dn);
        chk("empty done_cycle", 32'(dn), 32'd0);
        chk("empty no_req", 32'(req_cycles - req0), 32'd0);
        compare_pass("empty");

        // Randomized passes
        max_wait = 3;
        for (int k = 0; k < 24; k++) begin
            randomize_cfg();
            ren  = 4'($urandom);
            rpm  = 4'($urandom);
            rrow = 3'($urandom);
            rcol = 3'($urandom);
            run_pixel(ren, rpm, rrow, rcol, 1'b0, 1'b0, "rand", dn);
            compare_pass("rand");
        end

        // Reset while the character read is outstanding, then a late ack
        fixed_wait = 0;
        ack_limit  = ack_total + 1;
        @(negedge clock);
        bg_enable  = 4'b0001;
        bg_palmode = 4'b0000;
        pixel_go   = 1'b1;
        @(negedge clock);
        pixel_go   = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("midrst char_pending", 32'(vif.vram_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst vram_req", 32'(vif.vram_req), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst overrun", 32'(overrun), 32'd0);
        chk("midrst cur_bg", 32'(cur_bg), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        inject_ack = 1'b1;
        @(negedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock);
        #1 inject_ack = 1'b0;
        obs_q.delete();
        repeat (6) @(negedge clock);
        chk("midrst no_valid", 32'(obs_q.size()), 32'd0);
        chk("midrst idle", 32'(busy), 32'd0);
        chk("midrst out_data", 32'(out_data), 32'd0);
        chk("midrst out_palette", 32'(out_paletteno), 32'd0);
        chk("midrst out_bgused", 32'(out_bgused), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        ack_limit  = 32'h3FFF_FFFF;
        fixed_wait = -1;
        acc_q.delete();
        obs_q.delete();

        // pixel_go in the done cycle
        do_reset();
        randomize_cfg();
        max_wait = 1;
        run_pixel(4'b0011, 4'b0010, 3'd5, 3'd3, 1'b0, 1'b1, "go_at_done", dn);
        compare_pass("go_at_done");
        chk("go_at_done overrun", 32'(overrun), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
